proc_ctrl_fsm: RTL and testbench
================================

Name: proc_ctrl_fsm

Overview:
- Control unit for the simple 16-bit processor datapath: eight registers R0..R7, A, G, the add/sub ALU, and the 16-bit shared bus multiplexer.
- Loads the instruction word from DIN into an internal IR.
- Sequences each instruction over 2 or 4 clock cycles, generating the bus-driver selects (Rout, Gout, DINout) and register load enables (Rin, Ain, Gin, IRin).
- Drives the ALU mode (AddSub) and pulses Done at the end of each instruction.

Parameters:
DATA_W, 16, width of DIN and of the bus
IR_W, 9, instruction width, taken from DIN[IR_W-1:0], format III XXX YYY
NREG, 8, number of general registers; Rout/Rin width

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Run  input  1  start request, sampled in T0
DIN  input  DATA_W  instruction word (T0) / immediate (mvi, T1)
Rout  output  NREG  one-hot bus select, bit 7 = R0 ... bit 0 = R7
Rin  output  NREG  one-hot register load enable, same bit order as Rout
Gout  output  1  drive G onto bus
DINout  output  1  drive DIN onto bus
Ain  output  1  load A from bus
Gin  output  1  load G from ALU
AddSub  output  1  0 = A+bus, 1 = A-bus
IRin  output  1  load IR from DIN
Done  output  1  one-cycle pulse, instruction complete
Busy  output  1  high in T1..T3

Behaviour:
- Interface: one clock, Clock; Reset is synchronous and active-high. While Reset is high at a rising edge: state <= T0, IR <= 0. Reset mid-instruction aborts it; no Rin/Gin/Ain is asserted in the cycle after Reset.
- Reset values: every output is 0, except IRin, which follows Run in T0.
- States: T0 (fetch/idle), T1, T2, T3. 2-bit state register.
- Opcodes (IR[8:6]): 000 mv, 001 mvi, 010 add, 011 sub, 100..111 illegal. X = IR[5:3], Y = IR[2:0].
- T0:
  - IRin = Run.
  - If Run, IR <= DIN[8:0] and next state = T1; otherwise stay in T0.
  - No bus driver and no Rin in T0.
- T1:
  - mv: Rout = onehot(Y), Rin = onehot(X), Done = 1, next T0.
  - mvi: DINout = 1, Rin = onehot(X), Done = 1, next T0.
  - add/sub: Rout = onehot(X), Ain = 1, next T2.
  - Illegal: Done = 1, no other output, next T0.
- T2 (add/sub): Rout = onehot(Y), Gin = 1, AddSub = (opcode == sub), next T3.
- T3 (add/sub): Gout = 1, Rin = onehot(X), Done = 1, next T0.
- Latency: mv/mvi take 2 cycles from Run sampled; add/sub take 4.
- Outputs are Moore-style combinational decodes of (state, IR), except T0 IRin, which follows Run.
- Invariant: at most one bus driver active per cycle (Rout nonzero, Gout, DINout mutually exclusive). Rin is at most one-hot.
- The bus mux is event-driven, so each selection change appears as a change on Rout, Gout or DINout.
- Run is ignored outside T0. Back-to-back: Run high in the T0 following Done starts the next fetch; minimum issue interval is 2 cycles.
- X == Y is legal: mv Rx,Rx drives and loads the same register. add Rx,Rx doubles Rx.
- Busy = (state != T0).

Decomposition:
- Package proc_ctrl_pkg holds:
  - opcode localparams OP_MV, OP_MVI, OP_ADD, OP_SUB;
  - state encoding T0..T3;
  - IR field slice positions.
- One sub-module, reg_dec3to8: 3-bit index to 8-bit one-hot, MSB = R0, with an enable input (output 0 when disabled). Instantiated twice, once for Rout and once for Rin.

Test Plan:
- Reset high 2 cycles mid add (in T2) -> next cycle state T0, all outputs 0, Gin never follows.
- Run=1, DIN=9'b000_010_101 (mv R2,R5) -> T1: Rout=8'b0000_0100, Rin=8'b0010_0000, Done=1; Busy high 1 cycle.
- Run=1, DIN=9'b001_011_000, then DIN=16'h00A5 (mvi R3,#A5) -> T1: DINout=1, Rin=8'b0001_0000, Done=1, Rout=0.
- Run=1, DIN=9'b011_000_001 (sub R0,R1) -> T1: Rout=8'h80, Ain=1; T2: Rout=8'h40, Gin=1, AddSub=1; T3: Gout=1, Rin=8'h80, Done=1.
- Run held high over add then mv back-to-back -> second IRin in the cycle after first Done; bus-driver exclusivity assertion never fires.
- Run=1, DIN=9'b111_000_000 (illegal) -> T1: Done=1, all other outputs 0, back to T0; Run low in T0 -> stays in T0, IRin=0.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the processor control unit: opcodes, sequencing
// states and instruction-word field positions (format III XXX YYY).
package proc_ctrl_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } state_t;

  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int X_MSB  = 5;
  localparam int X_LSB  = 3;
  localparam int Y_MSB  = 2;
  localparam int Y_LSB  = 0;

  function automatic logic [2:0] ir_op(input logic [8:0] ir);
    return ir[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [2:0] ir_x(input logic [8:0] ir);
    return ir[X_MSB:X_LSB];
  endfunction

  function automatic logic [2:0] ir_y(input logic [8:0] ir);
    return ir[Y_MSB:Y_LSB];
  endfunction

endpackage

// File: rtl/reg_dec3to8.sv
// Register index decoder: 3-bit index to one-hot select, bit 7 = R0 ... bit 0 = R7.
// The whole output is forced to zero when the enable is low.
module reg_dec3to8
  import proc_ctrl_pkg::*;
(
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] onehot
);

  // Shift a single bit down from the R0 position by the register index
  always_comb begin
    onehot = 8'b0000_0000;
    if (en) begin
      onehot = 8'b1000_0000 >> idx;
    end else begin
      onehot = 8'b0000_0000;
    end
  end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Control sequencer for the 16-bit bus processor: fetches the instruction into IR
// and walks T0..T3, decoding bus-driver selects and register load enables.
module proc_ctrl_fsm
  import proc_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IR_W   = 9,
  parameter int NREG   = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic [NREG-1:0]   Rout,
  output logic [NREG-1:0]   Rin,
  output logic              Gout,
  output logic              DINout,
  output logic              Ain,
  output logic              Gin,
  output logic              AddSub,
  output logic              IRin,
  output logic              Done,
  output logic              Busy
);

  state_t            state;
  state_t            next_state;
  logic [IR_W-1:0]   ir;
  logic [2:0]        op;
  logic [2:0]        x_idx;
  logic [2:0]        y_idx;
  logic [2:0]        rout_idx;
  logic              rout_en;
  logic [2:0]        rin_idx;
  logic              rin_en;
  logic              din_unused;

  // Only the low IR_W bits of DIN carry the instruction; the rest feed the bus only
  assign din_unused = ^DIN[DATA_W-1:IR_W];

  assign op    = ir_op(ir);
  assign x_idx = ir_x(ir);
  assign y_idx = ir_y(ir);
  assign Busy  = (state != T0);

  // Sequencing state register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= T0;
    end else begin
      state <= next_state;
    end
  end

  // Instruction register, captured only when a fetch is accepted in T0
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ir <= {IR_W{1'b0}};
    end else if ((state == T0) && Run) begin
      ir <= DIN[IR_W-1:0];
    end else begin
      ir <= ir;
    end
  end

  // Next-state and control decode from (state, IR); IRin alone follows Run
  always_comb begin
    next_state = state;
    rout_idx   = 3'd0;
    rout_en    = 1'b0;
    rin_idx    = 3'd0;
    rin_en     = 1'b0;
    Gout       = 1'b0;
    DINout     = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    AddSub     = 1'b0;
    IRin       = 1'b0;
    Done       = 1'b0;
    case (state)
      T0: begin
        IRin = Run;
        if (Run) begin
          next_state = T1;
        end else begin
          next_state = T0;
        end
      end
      T1: begin
        case (op)
          OP_MV: begin
            rout_idx   = y_idx;
            rout_en    = 1'b1;
            rin_idx    = x_idx;
            rin_en     = 1'b1;
            Done       = 1'b1;
            next_state = T0;
          end
          OP_MVI: begin
            DINout     = 1'b1;
            rin_idx    = x_idx;
            rin_en     = 1'b1;
            Done       = 1'b1;
            next_state = T0;
          end
          OP_ADD, OP_SUB: begin
            rout_idx   = x_idx;
            rout_en    = 1'b1;
            Ain        = 1'b1;
            next_state = T2;
          end
          default: begin
            // Illegal opcode: retire immediately without touching the datapath
            Done       = 1'b1;
            next_state = T0;
          end
        endcase
      end
      T2: begin
        rout_idx   = y_idx;
        rout_en    = 1'b1;
        Gin        = 1'b1;
        AddSub     = (op == OP_SUB);
        next_state = T3;
      end
      T3: begin
        Gout       = 1'b1;
        rin_idx    = x_idx;
        rin_en     = 1'b1;
        Done       = 1'b1;
        next_state = T0;
      end
      default: begin
        next_state = T0;
      end
    endcase
  end

  reg_dec3to8 u_rout_dec (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (Rout)
  );

  reg_dec3to8 u_rin_dec (
    .idx    (rin_idx),
    .en     (rin_en),
    .onehot (Rin)
  );

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Randomized bench for proc_ctrl_fsm: a queue of per-cycle expected control words
// per accepted instruction, plus directed checks of the documented sequences.
module tb_proc_ctrl_fsm;

  typedef struct packed {
    logic [7:0] rout;
    logic [7:0] rin;
    logic       gout;
    logic       dinout;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       irin;
    logic       done;
    logic       busy;
  } exp_t;

  logic        Clock;
  logic        Reset;
  logic        Run;
  logic [15:0] DIN;
  logic [7:0]  Rout;
  logic [7:0]  Rin;
  logic        Gout;
  logic        DINout;
  logic        Ain;
  logic        Gin;
  logic        AddSub;
  logic        IRin;
  logic        Done;
  logic        Busy;
  logic [23:0] got_v;

  int   checks;
  int   passes;
  exp_t pending[$];

  proc_ctrl_fsm dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Run    (Run),
    .DIN    (DIN),
    .Rout   (Rout),
    .Rin    (Rin),
    .Gout   (Gout),
    .DINout (DINout),
    .Ain    (Ain),
    .Gin    (Gin),
    .AddSub (AddSub),
    .IRin   (IRin),
    .Done   (Done),
    .Busy   (Busy)
  );

  assign got_v = {Rout, Rin, Gout, DINout, Ain, Gin, AddSub, IRin, Done, Busy};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end else begin
      passes++;
    end
  endtask

  function automatic logic [7:0] reg_bit(input logic [2:0] r);
    logic [7:0] one;
    one = 8'd1;
    return one << (3'd7 - r);
  endfunction

  // Expand one accepted instruction into its sequence of per-cycle control words
  function automatic void push_instr(input logic [8:0] w);
    exp_t e;
    int op;
    logic [2:0] x;
    logic [2:0] y;
    op = int'(w[8:6]);
    x  = w[5:3];
    y  = w[2:0];
    e = '0; e.busy = 1'b1;
    if (op == 0) begin
      e.rout = reg_bit(y); e.rin = reg_bit(x); e.done = 1'b1;
      pending.push_back(e);
    end else if (op == 1) begin
      e.dinout = 1'b1; e.rin = reg_bit(x); e.done = 1'b1;
      pending.push_back(e);
    end else if (op == 2 || op == 3) begin
      e.rout = reg_bit(x); e.ain = 1'b1;
      pending.push_back(e);
      e = '0; e.busy = 1'b1;
      e.rout = reg_bit(y); e.gin = 1'b1; e.addsub = (op == 3);
      pending.push_back(e);
      e = '0; e.busy = 1'b1;
      e.gout = 1'b1; e.rin = reg_bit(x); e.done = 1'b1;
      pending.push_back(e);
    end else begin
      e.done = 1'b1;
      pending.push_back(e);
    end
  endfunction

  // Drive inputs, then on the falling edge compare against the model and invariants
  task automatic apply(input logic run_v, input logic [15:0] din_v, input logic rst_v);
    exp_t e;
    int drivers;
    Run   = run_v;
    DIN   = din_v;
    Reset = rst_v;
    @(negedge Clock);
    if (pending.size() == 0) begin
      e = '0;
      e.irin = Run;
    end else begin
      e = pending[0];
    end
    check_eq("model", {8'd0, got_v}, {8'd0, 24'(e)});
    drivers = int'(Rout != 8'd0) + int'(Gout) + int'(DINout);
    check_eq("bus_excl", {31'd0, drivers <= 1}, 32'd1);
    check_eq("rin_onehot", {31'd0, $countones(Rin) <= 1}, 32'd1);
  endtask

  // Advance one clock and update the model with the inputs that were sampled
  task automatic adv();
    @(posedge Clock);
    if (Reset) begin
      pending.delete();
    end else if (pending.size() == 0) begin
      if (Run) push_instr(DIN[8:0]);
    end else begin
      void'(pending.pop_front());
    end
    #1;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    Run    = 1'b0;
    DIN    = 16'h0000;
    Reset  = 1'b1;
    @(posedge Clock);
    #1;
    Reset  = 1'b0;

    apply(1'b0, 16'h0000, 1'b0);
    check_eq("reset_idle", {8'd0, got_v}, 32'd0);
    adv();

    // mv R2,R5
    apply(1'b1, 16'h0015, 1'b0);
    check_eq("mv_irin", {31'd0, IRin}, 32'd1);
    adv();
    apply(1'b0, 16'h0000, 1'b0);
    check_eq("mv_rout", {24'd0, Rout}, 32'h04);
    check_eq("mv_rin", {24'd0, Rin}, 32'h20);
    check_eq("mv_done_busy", {30'd0, Done, Busy}, 32'd3);
    adv();
    apply(1'b0, 16'h0000, 1'b0);
    check_eq("mv_busy_end", {31'd0, Busy}, 32'd0);
    adv();

    // mvi R3,#A5
    apply(1'b1, 16'h0058, 1'b0);
    adv();
    apply(1'b0, 16'h00A5, 1'b0);
    check_eq("mvi_dinout", {31'd0, DINout}, 32'd1);
    check_eq("mvi_rin", {24'd0, Rin}, 32'h10);
    check_eq("mvi_rout", {24'd0, Rout}, 32'h00);
    check_eq("mvi_done", {31'd0, Done}, 32'd1);
    adv();

    // sub R0,R1
    apply(1'b1, 16'h00C1, 1'b0);
    adv();
    apply(1'b0, 16'h0000, 1'b0);
    check_eq("sub_t1", {15'd0, Rout, Ain, Gin, Done}, {15'd0, 8'h80, 3'b100});
    adv();
    apply(1'b0, 16'h0000, 1'b0);
    check_eq("sub_t2", {14'd0, Rout, Gin, AddSub, Ain, Done}, {14'd0, 8'h40, 4'b1100});
    adv();
    apply(1'b0, 16'h0000, 1'b0);
    check_eq("sub_t3", {14'd0, Rin, Gout, Done, Rout}, {14'd0, 8'h80, 2'b11, 8'h00});
    adv();

    // add R1,R2 aborted by a two-cycle reset while in T2
    apply(1'b1, 16'h008A, 1'b0);
    adv();
    apply(1'b0, 16'h0000, 1'b0);
    adv();
    apply(1'b0, 16'h0000, 1'b1);
    adv();
    apply(1'b0, 16'h0000, 1'b1);
    check_eq("rst_mid_idle", {8'd0, got_v}, 32'd0);
    adv();
    apply(1'b0, 16'h0000, 1'b0);
    check_eq("rst_no_gin", {8'd0, got_v}, 32'd0);
    adv();

    // add R4,R4 then mv R6,R1 with Run held high
    apply(1'b1, 16'h00A4, 1'b0);
    adv();
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 16'h0031, 1'b0);
      check_eq("b2b_no_irin", {31'd0, IRin}, 32'd0);
      adv();
    end
    apply(1'b1, 16'h0031, 1'b0);
    check_eq("b2b_irin", {31'd0, IRin}, 32'd1);
    adv();
    apply(1'b1, 16'h0031, 1'b0);
    check_eq("b2b_mv", {16'd0, Rout, Rin}, {16'd0, 8'h40, 8'h02});
    adv();
    apply(1'b0, 16'h0000, 1'b0);
    adv();

    // illegal opcode, then idle with Run low
    apply(1'b1, 16'h01C0, 1'b0);
    adv();
    apply(1'b0, 16'h0000, 1'b0);
    check_eq("ill_t1", {8'd0, got_v}, 32'h000003);
    adv();
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 16'hFFFF, 1'b0);
      check_eq("idle_stay", {8'd0, got_v}, 32'd0);
      adv();
    end

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom % 4) != 0, 16'($urandom), ($urandom % 40) == 0);
      adv();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
